uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1000, clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port re  input  1  read acknowledge; clears valid, frame_err and overrun.
REQ-006 SHALL have port dout  output  8  last correctly framed byte.
REQ-007 SHALL have port valid  output  1  dout holds an unread byte.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port frame_err  output  1  sticky; last frame had a low stop bit.
REQ-010 SHALL have port overrun  output  1  sticky; a byte completed while valid was high and re was low.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer (rx_s); both flops reset to 1; only rx_s feeds the state machine.
REQ-012 SHALL implement states IDLE, START_BIT, DATA_BITS and STOP_BIT, using a 16-bit bit-period counter and a 3-bit bit index.
REQ-013 IDLE: when rx_s==0, SHALL go to START_BIT with count=0 and index=0; otherwise SHALL stay in IDLE.
REQ-014 START_BIT: SHALL increment count each cycle; at count==CLKS_PER_BIT/2-1 (integer division), SHALL sample rx_s.
REQ-015 START_BIT sample: if rx_s==0, SHALL go to DATA_BITS with count=0; if rx_s==1, SHALL treat it as a glitch and return to IDLE, with no flag change.
REQ-016 DATA_BITS: at count==CLKS_PER_BIT-1, SHALL sample rx_s into the shift register LSB-first (shift right, new bit enters bit 7), reset count to 0 and increment index.
REQ-017 DATA_BITS: after the sample taken with index==7, SHALL go to STOP_BIT.
REQ-018 STOP_BIT: at count==CLKS_PER_BIT-1, SHALL sample rx_s and return to IDLE.
REQ-019 STOP_BIT sample==1: SHALL load dout with the shift register, set valid, and clear frame_err.
REQ-020 STOP_BIT sample==0: SHALL set frame_err and leave dout and valid unchanged.
REQ-021 Latency: valid SHALL rise CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the edge on which IDLE sees rx_s==0.
REQ-022 re high with no completing byte: SHALL clear valid, frame_err and overrun on the next edge.
REQ-023 Good byte completing while valid==1 and re==0: SHALL overwrite dout and set overrun.
REQ-024 Good byte completing in the same cycle as re==1: SHALL load the new byte, keep valid=1, and clear overrun and frame_err (new-byte set wins over clear for valid).
REQ-025 Framing error in the same cycle as re==1: SHALL set frame_err and clear valid and overrun.
REQ-026 SHALL ignore re while valid, frame_err and overrun are all low.
REQ-027 A line held low (break) SHALL produce one framing error, then remain in IDLE until rx_s returns high and falls again (IDLE re-arms only after seeing rx_s==1).

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, count=0, index=0, shift register=0, dout=8'h00, valid=0, busy=0, frame_err=0, overrun=0, and synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no flag set; after release, SHALL wait for a new falling edge.

Verification (CLKS_PER_BIT=16)
REQ-030 Send 8'hA5 at 16 cycles/bit -> valid rises 8+144=152 cycles after detection, dout=8'hA5, frame_err=0; re pulse -> valid=0.
REQ-031 2-cycle low glitch on idle rx -> returns to IDLE at the START_BIT sample; valid=0, frame_err=0, busy falls.
REQ-032 Send 8'h3C with stop bit driven low -> frame_err=1, valid=0, dout unchanged (8'h00 after reset).
REQ-033 Send 8'h11 then 8'h22 with no re -> dout=8'h22, valid=1, overrun=1; re -> all three flags cleared.
REQ-034 Assert re on the exact cycle 8'h22 completes -> valid=1, overrun=0, dout=8'h22.
REQ-035 Assert rst_n low during bit 4 of a frame -> all outputs at reset values; next full frame 8'h5A received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, read acknowledge and receive status bundle for uart_rx
interface uart_rx_if;
    logic       rx;
    logic       re;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx,
        output re,
        input  dout,
        input  valid,
        input  busy,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx,
        input  re,
        output dout,
        output valid,
        output busy,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and sticky framing/overrun flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 1000
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic [2:0]  index_q;
    logic [7:0]  shift_q;
    logic [7:0]  dout_q;
    logic        valid_q;
    logic        busy_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        armed_q;
    logic        sync1_q;
    logic        rx_s_q;
    logic        stop_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            rx_s_q  <= sync1_q;
        end
    end

    assign stop_done = (state_q == STOP_BIT) && (count_q == FULL_M1);

    // armed_q keeps a held-low line (break) from retriggering until it has been seen high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 16'd0;
            index_q     <= 3'd0;
            shift_q     <= 8'h00;
            dout_q      <= 8'h00;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q && armed_q) begin
                        state_q <= START_BIT;
                        busy_q  <= 1'b1;
                        count_q <= 16'd0;
                        index_q <= 3'd0;
                    end else if (rx_s_q) begin
                        armed_q <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (count_q == HALF_M1) begin
                        count_q <= 16'd0;
                        if (!rx_s_q) begin
                            state_q <= DATA_BITS;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (count_q == FULL_M1) begin
                        count_q <= 16'd0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        index_q <= index_q + 3'd1;
                        if (index_q == 3'd7) begin
                            state_q <= STOP_BIT;
                        end
                    end else begin
                        count_q <= count_q + 16'd1;
                    end
                end
                STOP_BIT: begin
                    if (stop_done) begin
                        count_q <= 16'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!rx_s_q) begin
                            armed_q <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A completing byte takes priority over a simultaneous read acknowledge
            if (stop_done && rx_s_q) begin
                dout_q      <= shift_q;
                valid_q     <= 1'b1;
                frame_err_q <= 1'b0;
                overrun_q   <= valid_q && !bus.re;
            end else if (stop_done) begin
                frame_err_q <= 1'b1;
                if (bus.re) begin
                    valid_q   <= 1'b0;
                    overrun_q <= 1'b0;
                end
            end else if (bus.re) begin
                valid_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule
